jedro_1_alu_arbiter: RTL

//  Shares the single registered ALU (1-cycle result latency) between two requesters
//  (port 0: execute/decode path, port 1: address/auxiliary path) via valid/ready.

---
 rtl/jedro_1_alu_arbiter_pkg.sv | 28 ++
 rtl/jedro_1_alu_arbiter_rr_arb2.sv | 13 +
 rtl/jedro_1_alu_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/jedro_1_alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode encoding,
// widths and arbiter state encoding.
package jedro_1_alu_arbiter_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'h1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'h2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'h3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'h4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'h5;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'b00,
        ARB_ST_BUSY = 2'b01,
        ARB_ST_HOLD = 2'b10
    } arb_state_e;

    // Two-way grant: a lone requester wins, a tie goes to prio.
    function automatic logic [1:0] rr_grant(logic [1:0] req, logic prio);
        logic [1:0] g;
        g = req;
        if (&req) g = prio ? 2'b10 : 2'b01;
        return g;
    endfunction

endpackage

// File: rtl/jedro_1_alu_arbiter_rr_arb2.sv
// Two-way round-robin grant with external priority pointer.
// Output grant is one-hot, or zero when nobody requests.
module jedro_1_rr_arb2
    import jedro_1_alu_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    assign gnt = rr_grant(req, prio);

endmodule

// File: rtl/jedro_1_alu_arbiter.sv
// Shares one registered ALU between two requesters, with a
// one-entry hold buffer for stalled responses.
module jedro_1_alu_arbiter
    import jedro_1_alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = jedro_1_alu_arbiter_pkg::DATA_WIDTH,
    parameter int OP_WIDTH   = ALU_OP_WIDTH,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [OP_WIDTH-1:0]   req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_opa_i,
    input  logic [DATA_WIDTH-1:0] req0_opb_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [OP_WIDTH-1:0]   req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_opa_i,
    input  logic [DATA_WIDTH-1:0] req1_opb_i,
    output logic                  rsp0_valid_o,
    input  logic                  rsp0_ready_i,
    output logic                  rsp1_valid_o,
    input  logic                  rsp1_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_res_o,
    output logic                  rsp_overflow_o,
    output logic [OP_WIDTH-1:0]   alu_op_sel_o,
    output logic [DATA_WIDTH-1:0] alu_opa_o,
    output logic [DATA_WIDTH-1:0] alu_opb_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic                  alu_overflow_i
);

    arb_state_e            state;
    logic                  tag;
    logic                  prio;
    logic [DATA_WIDTH-1:0] buf_res;
    logic                  buf_ovf;

    logic [1:0] req_v;
    logic [1:0] gnt;
    logic       tag_ready;
    logic       can_issue;
    logic       issue;
    logic       gnt_idx;
    logic       rsp_active;

    assign req_v = {req1_valid_i, req0_valid_i};

    jedro_1_rr_arb2 u_arb (
        .req  (req_v),
        .prio (prio),
        .gnt  (gnt)
    );

    assign tag_ready = tag ? rsp1_ready_i : rsp0_ready_i;

    // rstn_i gating keeps ready low while reset is held.
    assign can_issue = rstn_i & !flush_i &
                       ((state == ARB_ST_IDLE) |
                        ((state == ARB_ST_BUSY) & tag_ready));

    assign issue        = can_issue & (|gnt);
    assign gnt_idx      = gnt[1];
    assign req0_ready_o = can_issue & gnt[0];
    assign req1_ready_o = can_issue & gnt[1];

    always_comb begin
        alu_op_sel_o = '0;
        alu_opa_o    = '0;
        alu_opb_o    = '0;
        if (issue) begin
            alu_op_sel_o = gnt_idx ? req1_op_i  : req0_op_i;
            alu_opa_o    = gnt_idx ? req1_opa_i : req0_opa_i;
            alu_opb_o    = gnt_idx ? req1_opb_i : req0_opb_i;
        end
    end

    assign rsp_active   = !flush_i & (state != ARB_ST_IDLE);
    assign rsp0_valid_o = rsp_active & !tag;
    assign rsp1_valid_o = rsp_active & tag;

    always_comb begin
        rsp_res_o      = '0;
        rsp_overflow_o = 1'b0;
        if (state == ARB_ST_BUSY) begin
            rsp_res_o      = alu_res_i;
            rsp_overflow_o = alu_overflow_i;
        end else if (state == ARB_ST_HOLD) begin
            rsp_res_o      = buf_res;
            rsp_overflow_o = buf_ovf;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ARB_ST_IDLE;
            tag     <= 1'b0;
            prio    <= 1'b0;
            buf_res <= '0;
            buf_ovf <= 1'b0;
        end else begin
            if (issue) begin
                tag  <= gnt_idx;
                prio <= RR_EN ? ~gnt_idx : 1'b0;
            end
            if (flush_i) begin
                state <= ARB_ST_IDLE;
            end else begin
                unique case (state)
                    ARB_ST_IDLE: begin
                        state <= issue ? ARB_ST_BUSY : ARB_ST_IDLE;
                    end
                    ARB_ST_BUSY: begin
                        // ALU register is overwritten next cycle: park the result.
                        if (!tag_ready) begin
                            buf_res <= alu_res_i;
                            buf_ovf <= alu_overflow_i;
                            state   <= ARB_ST_HOLD;
                        end else begin
                            state <= issue ? ARB_ST_BUSY : ARB_ST_IDLE;
                        end
                    end
                    ARB_ST_HOLD: begin
                        if (tag_ready) state <= ARB_ST_IDLE;
                    end
                    default: state <= ARB_ST_IDLE;
                endcase
            end
        end
    end

endmodule
